// File: rtl/cpu_pkg.sv
// Shared encodings for the bus-based 32-bit CPU: opcodes, ALU selects,
// control-unit step states and the instruction classes the sequencer uses.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Address calculation always runs through the adder.
  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_REG, CL_NEGNOT, CL_IMM, CL_LDI, CL_LD, CL_ST, CL_MULDIV,
    CL_MFHI, CL_MFLO, CL_JR, CL_NOP, CL_HALT, CL_ILLEGAL
  } class_t;

endpackage

// File: rtl/control_unit_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// the sequencer's inputs (start, IR contents, memory completion) and every
// datapath strobe it drives.
interface control_unit_if;
  logic        start;
  logic [31:0] ir;
  logic        mem_done;

  logic        Gra, Grb, Grc;
  logic        Rin, Rout, BAout, Cout;
  logic        PCout, PCin, IncPC, IRin;
  logic        MARin, MDRin, MDRout;
  logic        read, write;
  logic        Yin, Zin, Zhighout, Zlowout;
  logic        HIin, HIout, LOin, LOout;
  logic [4:0]  alu_op;
  logic        run;
  logic        illegal;

  modport master (
    input  start, ir, mem_done,
    output Gra, Grb, Grc, Rin, Rout, BAout, Cout,
           PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
           read, write, Yin, Zin, Zhighout, Zlowout,
           HIin, HIout, LOin, LOout, alu_op, run, illegal
  );

  modport slave (
    output start, ir, mem_done,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Cout,
           PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout,
           read, write, Yin, Zin, Zhighout, Zlowout,
           HIin, HIout, LOin, LOout, alu_op, run, illegal
  );
endinterface

// File: rtl/control_decode.sv
// Opcode decoder: maps the 5-bit opcode to an instruction class and the ALU
// select. Macro CU_MULDIV_EN enables mul/div; without it they decode as
// illegal.
module control_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output class_t     op_class,
  output logic [4:0] alu_op
);

  // Classify the opcode; load/store/ldi force the adder for address math.
  always_comb begin
    op_class = CL_ILLEGAL;
    alu_op   = opcode;
    case (opcode) inside
      OP_LD:                  begin op_class = CL_LD;  alu_op = ALU_ADD; end
      OP_LDI:                 begin op_class = CL_LDI; alu_op = ALU_ADD; end
      OP_ST:                  begin op_class = CL_ST;  alu_op = ALU_ADD; end
      [OP_ADD:OP_SHL]:        op_class = CL_REG;
      OP_ADDI, OP_ANDI,
      OP_ORI:                 op_class = CL_IMM;
      OP_NEG, OP_NOT:         op_class = CL_NEGNOT;
`ifdef CU_MULDIV_EN
      OP_DIV, OP_MUL:         op_class = CL_MULDIV;
`endif
      OP_JR:                  op_class = CL_JR;
      OP_MFLO:                op_class = CL_MFLO;
      OP_MFHI:                op_class = CL_MFHI;
      OP_NOP:                 op_class = CL_NOP;
      OP_HALT:                op_class = CL_HALT;
      default:                op_class = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Sequencer for the bus-based 32-bit datapath. Moore FSM stepping through
// fetch (T0-T2) and execute (T3-T7), stalling on memory in T1 and the load/
// store memory steps. Strobes decode from the state and the IR contents.
// Macro CU_MULDIV_EN enables the mul/div execute sequence.
module control_unit
  import cpu_pkg::*;
(
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master bus
);

  state_t     state;
  logic       illegal_q;
  class_t     op_class;
  logic [4:0] dec_alu;
  logic       unused_ir_fields;

  assign unused_ir_fields = ^bus.ir[26:0];

  control_decode u_decode (
    .opcode   (bus.ir[31:27]),
    .op_class (op_class),
    .alu_op   (dec_alu)
  );

  // Step sequencing and the sticky illegal-opcode flag.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1:   if (bus.mem_done) state <= ST_T2;
        ST_T2: begin
          case (op_class)
            CL_NOP:     state <= ST_T0;
            CL_HALT:    state <= ST_HALT;
            CL_ILLEGAL: begin
              state     <= ST_HALT;
              illegal_q <= 1'b1;
            end
            default:    state <= ST_T3;
          endcase
        end
        ST_T3: begin
          case (op_class)
            CL_MFHI, CL_MFLO, CL_JR: state <= ST_T0;
            default:                 state <= ST_T4;
          endcase
        end
        ST_T4: begin
          case (op_class)
            CL_NEGNOT: state <= ST_T0;
            default:   state <= ST_T5;
          endcase
        end
        ST_T5: begin
          case (op_class)
            CL_LD, CL_ST, CL_MULDIV: state <= ST_T6;
            default:                 state <= ST_T0;
          endcase
        end
        ST_T6: begin
          case (op_class)
            CL_LD:   if (bus.mem_done) state <= ST_T7;
            CL_ST:   state <= ST_T7;
            default: state <= ST_T0;
          endcase
        end
        ST_T7: begin
          case (op_class)
            CL_ST:   if (bus.mem_done) state <= ST_T0;
            default: state <= ST_T0;
          endcase
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobe decode from the current step and the instruction class.
  always_comb begin
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.BAout    = 1'b0;
    bus.Cout     = 1'b0;
    bus.PCout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.IRin     = 1'b0;
    bus.MARin    = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.HIin     = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOin     = 1'b0;
    bus.LOout    = 1'b0;
    bus.alu_op   = 5'd0;
    bus.run      = (state != ST_IDLE) && (state != ST_HALT);
    bus.illegal  = illegal_q;

    case (state)
      ST_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      ST_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1;
      end
      ST_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      ST_T3: begin
        bus.alu_op = dec_alu;
        case (op_class)
          CL_REG, CL_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
          CL_NEGNOT:      begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; end
          CL_LDI, CL_LD,
          CL_ST:          begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
          CL_MULDIV:      begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
          CL_MFHI:        begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_MFLO:        begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_JR:          begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        bus.alu_op = dec_alu;
        case (op_class)
          CL_REG:         begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; end
          CL_IMM, CL_LDI,
          CL_LD, CL_ST:   begin bus.Cout = 1'b1; bus.Zin = 1'b1; end
          CL_NEGNOT:      begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_MULDIV:      begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        bus.alu_op = dec_alu;
        case (op_class)
          CL_REG, CL_IMM,
          CL_LDI:         begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_LD, CL_ST:   begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
          CL_MULDIV:      begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        bus.alu_op = dec_alu;
        case (op_class)
          CL_LD:          begin bus.read = 1'b1; bus.MDRin = 1'b1; end
          CL_ST:          begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
`ifdef CU_MULDIV_EN
          CL_MULDIV:      begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
`endif
          default: ;
        endcase
      end
      ST_T7: begin
        bus.alu_op = dec_alu;
        case (op_class)
          CL_LD:          begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          CL_ST:          bus.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a driver pushes the expected output
// vector for every cycle it drives, a negedge checker pops and compares.
module tb_control_unit;

  logic clock = 1'b0;
  logic clear;

  control_unit_if bus();

  control_unit dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  localparam logic [23:0] GRA = 24'h800000, GRB = 24'h400000, GRC = 24'h200000,
    RIN = 24'h100000, ROUT = 24'h080000, BAOUT = 24'h040000, COUT = 24'h020000,
    PCOUT = 24'h010000, PCIN = 24'h008000, INCPC = 24'h004000, IRIN = 24'h002000,
    MARIN = 24'h001000, MDRIN = 24'h000800, MDROUT = 24'h000400, READ = 24'h000200,
    WRITE = 24'h000100, YIN = 24'h000080, ZIN = 24'h000040, ZHIGHOUT = 24'h000020,
    ZLOWOUT = 24'h000010, HIIN = 24'h000008, HIOUT = 24'h000004, LOIN = 24'h000002,
    LOOUT = 24'h000001;

  localparam logic [23:0] V_T0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [23:0] V_T1 = ZLOWOUT | PCIN | READ | MDRIN;
  localparam logic [23:0] V_T2 = MDROUT | IRIN;

  localparam logic [4:0] C_LD = 5'b00000, C_LDI = 5'b00001, C_ST = 5'b00010,
    C_ADD = 5'b00011, C_ADDI = 5'b01100, C_MUL = 5'b10000, C_NEG = 5'b10001,
    C_BR = 5'b10011, C_JR = 5'b10101, C_MFLO = 5'b11000, C_MFHI = 5'b11001,
    C_NOP = 5'b11010, C_HALT = 5'b11011, C_RSV = 5'b11111;

  logic [31:0] obs;
  assign obs = {1'b0, bus.illegal, bus.run, bus.alu_op,
                bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.Cout,
                bus.PCout, bus.PCin, bus.IncPC, bus.IRin, bus.MARin, bus.MDRin,
                bus.MDRout, bus.read, bus.write, bus.Yin, bus.Zin, bus.Zhighout,
                bus.Zlowout, bus.HIin, bus.HIout, bus.LOin, bus.LOout};

  int n_vec = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      string       t;
      logic [31:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check_vec(t, obs, e);
    end
  end

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    return {op, 4'd1, 4'd2, 4'd3, 15'd0};
  endfunction

  // One clock: drive inputs, queue what the outputs must be in this cycle.
  task automatic tick(input string tag, input logic md, input logic st,
                      input logic [23:0] s, input logic [4:0] a,
                      input logic r, input logic il);
    bus.mem_done = md;
    bus.start    = st;
    exp_q.push_back({1'b0, il, r, a, s});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  task automatic ex(input string tag, input logic [23:0] s, input logic [4:0] a);
    tick(tag, 1'b1, 1'b0, s, a, 1'b1, 1'b0);
  endtask

  task automatic fetch(input string tag, input logic [4:0] op);
    bus.ir = mk_ir(op);
    tick({tag, "_T0"}, 1'b1, 1'b0, V_T0, 5'd0, 1'b1, 1'b0);
    tick({tag, "_T1"}, 1'b1, 1'b0, V_T1, 5'd0, 1'b1, 1'b0);
    tick({tag, "_T2"}, 1'b1, 1'b0, V_T2, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    tick(tag, 1'b0, 1'b0, 24'd0, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear        = 1'b1;
    bus.start    = 1'b0;
    bus.mem_done = 1'b0;
    bus.ir       = mk_ir(C_ADD);
    @(posedge clock);
    #1;
    tick("reset", 1'b0, 1'b0, 24'd0, 5'd0, 1'b0, 1'b0);
    clear = 1'b0;

    // Stall in T1, then clear asynchronously mid-cycle.
    tick("idle_start", 1'b0, 1'b1, 24'd0, 5'd0, 1'b0, 1'b0);
    tick("stall_T0",   1'b0, 1'b0, V_T0, 5'd0, 1'b1, 1'b0);
    tick("stall_T1a",  1'b0, 1'b0, V_T1, 5'd0, 1'b1, 1'b0);
    tick("stall_T1b",  1'b0, 1'b0, V_T1, 5'd0, 1'b1, 1'b0);
    #2;
    check_vec("stall_read", {31'd0, bus.read}, 32'd1);
    clear = 1'b1;
    #1;
    check_vec("clr_read", {31'd0, bus.read}, 32'd0);
    check_vec("clr_run",  {31'd0, bus.run},  32'd0);
    check_vec("clr_all",  obs, 32'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    tick("restart", 1'b0, 1'b1, 24'd0, 5'd0, 1'b0, 1'b0);

    // add R1,R2,R3
    fetch("add", C_ADD);
    ex("add_T3", GRB | ROUT | YIN, C_ADD);
    ex("add_T4", GRC | ROUT | ZIN, C_ADD);
    ex("add_T5", ZLOWOUT | GRA | RIN, C_ADD);

    // ld with memory stalling three cycles in T6
    fetch("ld", C_LD);
    ex("ld_T3", GRB | BAOUT | YIN, C_ADD);
    ex("ld_T4", COUT | ZIN, C_ADD);
    ex("ld_T5", ZLOWOUT | MARIN, C_ADD);
    for (int i = 0; i < 3; i++)
      tick("ld_T6w", 1'b0, 1'b0, READ | MDRIN, C_ADD, 1'b1, 1'b0);
    ex("ld_T6", READ | MDRIN, C_ADD);
    ex("ld_T7", MDROUT | GRA | RIN, C_ADD);

    // st with one stall cycle on the write
    fetch("st", C_ST);
    ex("st_T3", GRB | BAOUT | YIN, C_ADD);
    ex("st_T4", COUT | ZIN, C_ADD);
    ex("st_T5", ZLOWOUT | MARIN, C_ADD);
    ex("st_T6", GRA | ROUT | MDRIN, C_ADD);
    tick("st_T7w", 1'b0, 1'b0, WRITE, C_ADD, 1'b1, 1'b0);
    ex("st_T7", WRITE, C_ADD);

    fetch("nop", C_NOP);
    fetch("jr", C_JR);
    ex("jr_T3", GRA | ROUT | PCIN, C_JR);
    fetch("mfhi", C_MFHI);
    ex("mfhi_T3", HIOUT | GRA | RIN, C_MFHI);
    fetch("mflo", C_MFLO);
    ex("mflo_T3", LOOUT | GRA | RIN, C_MFLO);
    fetch("neg", C_NEG);
    ex("neg_T3", GRB | ROUT | ZIN, C_NEG);
    ex("neg_T4", ZLOWOUT | GRA | RIN, C_NEG);
    fetch("addi", C_ADDI);
    ex("addi_T3", GRB | ROUT | YIN, C_ADDI);
    ex("addi_T4", COUT | ZIN, C_ADDI);
    ex("addi_T5", ZLOWOUT | GRA | RIN, C_ADDI);
    fetch("ldi", C_LDI);
    ex("ldi_T3", GRB | BAOUT | YIN, C_ADD);
    ex("ldi_T4", COUT | ZIN, C_ADD);
    ex("ldi_T5", ZLOWOUT | GRA | RIN, C_ADD);

    fetch("mul", C_MUL);
`ifdef CU_MULDIV_EN
    ex("mul_T3", GRA | ROUT | YIN, C_MUL);
    ex("mul_T4", GRB | ROUT | ZIN, C_MUL);
    ex("mul_T5", ZLOWOUT | LOIN, C_MUL);
    ex("mul_T6", ZHIGHOUT | HIIN, C_MUL);
    ex("mul_next", V_T0, 5'd0);
`else
    tick("mul_halt_a", 1'b1, 1'b1, 24'd0, 5'd0, 1'b0, 1'b1);
    tick("mul_halt_b", 1'b1, 1'b1, 24'd0, 5'd0, 1'b0, 1'b1);
`endif
    do_clear("clr_mul");

    // halt: ignores start until cleared
    tick("h_start", 1'b1, 1'b1, 24'd0, 5'd0, 1'b0, 1'b0);
    fetch("halt", C_HALT);
    for (int i = 0; i < 4; i++)
      tick("halt_hold", 1'b1, 1'b1, 24'd0, 5'd0, 1'b0, 1'b0);
    do_clear("clr_halt");

    // unsupported opcodes halt with the sticky illegal flag
    tick("br_start", 1'b1, 1'b1, 24'd0, 5'd0, 1'b0, 1'b0);
    fetch("br", C_BR);
    tick("br_halt_a", 1'b1, 1'b1, 24'd0, 5'd0, 1'b0, 1'b1);
    tick("br_halt_b", 1'b0, 1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
    do_clear("clr_br");
    tick("rsv_start", 1'b1, 1'b1, 24'd0, 5'd0, 1'b0, 1'b0);
    fetch("rsv", C_RSV);
    tick("rsv_halt", 1'b1, 1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
    do_clear("clr_rsv");
    tick("idle_end", 1'b1, 1'b0, 24'd0, 5'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
